// File: rtl/cpu_controller.sv
// cpu_controller
//   Moore control FSM for the simple RISC core. Sequences fetch, PC update,
//   decode and execute, and drives all datapath, register-file and memory
//   strobes.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   opcode[2:0], op[1:0]  instruction fields from the decoder
//   nsel[2:0]             register select one-hot (100 Rn, 010 Rd, 001 Rm)
//   vsel[1:0]             writeback source (00 C, 01 sximm8, 10 mdata)
//   write                 register-file write enable
//   loada/loadb/loadc/loads  datapath register loads
//   asel, bsel            operand muxes (A forced 0, B = sximm5)
//   load_ir, load_pc, reset_pc  instruction register / PC control
//   addr_sel, load_addr   memory address source / data address register load
//   mem_cmd[1:0]          00 none, 01 read, 10 write
//   halted                high in HALT
module cpu_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
    S_COMPUTE, S_WR_REG, S_ADDR, S_LOAD_ADDR, S_MEM_RD, S_WR_MEM,
    S_STR_PASS, S_MEM_WR, S_HALT
  } state_t;

  state_t state, state_next;

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_ldr, is_str, is_halt;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_ldr     = (opcode == 3'b011);
  assign is_str     = (opcode == 3'b100);
  assign is_halt    = (opcode == 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    nsel       = '0;
    vsel       = '0;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    reset_pc   = 1'b0;
    addr_sel   = 1'b0;
    load_addr  = 1'b0;
    mem_cmd    = 2'b00;
    halted     = 1'b0;

    unique case (state)
      S_RST: begin
        reset_pc   = 1'b1;
        load_pc    = 1'b1;
        state_next = S_IF1;
      end
      S_IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = 2'b01;
        state_next = S_IF2;
      end
      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = 2'b01;
        load_ir    = 1'b1;
        state_next = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        load_pc    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                  state_next = S_WR_IMM;
        else if (is_mov_reg)             state_next = S_GET_B;
        else if (is_alu || is_ldr || is_str) state_next = S_GET_A;
        else if (is_halt)                state_next = S_HALT;
        else                             state_next = S_IF1;
      end
      S_WR_IMM: begin
        nsel       = 3'b100;
        vsel       = 2'b01;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_GET_A: begin
        nsel       = 3'b100;
        loada      = 1'b1;
        state_next = (is_ldr || is_str) ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        // STR reaches here after address setup and needs Rd as store data.
        nsel       = is_str ? 3'b010 : 3'b001;
        loadb      = 1'b1;
        state_next = is_str ? S_STR_PASS : S_COMPUTE;
      end
      S_COMPUTE: begin
        asel = is_mov_reg;
        if (is_cmp) begin
          loads      = 1'b1;
          state_next = S_IF1;
        end else begin
          loadc      = 1'b1;
          state_next = S_WR_REG;
        end
      end
      S_WR_REG: begin
        nsel       = 3'b010;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_ADDR: begin
        bsel       = 1'b1;
        loadc      = 1'b1;
        state_next = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        load_addr  = 1'b1;
        state_next = is_str ? S_GET_B : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_cmd    = 2'b01;
        state_next = S_WR_MEM;
      end
      S_WR_MEM: begin
        mem_cmd    = 2'b01;
        nsel       = 3'b010;
        vsel       = 2'b10;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_STR_PASS: begin
        asel       = 1'b1;
        loadc      = 1'b1;
        state_next = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd    = 2'b10;
        state_next = S_IF1;
      end
      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
//   Drives directed and random instruction streams into cpu_controller and
//   compares every cycle's outputs to per-instruction micro-op sequences.
module tb_cpu_controller;

  logic       clk;
  logic       reset_n;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic       load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;
  logic [1:0] mem_cmd;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } outs_t;

  outs_t act;
  outs_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
    .halted(halted)
  );

  assign act = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t rst_vec();
    outs_t s = '0;
    s.reset_pc = 1'b1;
    s.load_pc  = 1'b1;
    return s;
  endfunction

  // Expected per-cycle outputs of one instruction, IF1 through its last state.
  function automatic void build(input logic [2:0] opc, input logic [1:0] o);
    outs_t s;
    exp_q.delete();
    s = '0; s.addr_sel = 1; s.mem_cmd = 2'b01; exp_q.push_back(s);
    s.load_ir = 1; exp_q.push_back(s);
    s = '0; s.load_pc = 1; exp_q.push_back(s);
    s = '0; exp_q.push_back(s);
    if (opc == 3'b110 && o == 2'b10) begin
      s = '0; s.nsel = 3'b100; s.vsel = 2'b01; s.write = 1; exp_q.push_back(s);
    end else if (opc == 3'b101 || (opc == 3'b110 && o == 2'b00)) begin
      if (opc == 3'b101) begin
        s = '0; s.nsel = 3'b100; s.loada = 1; exp_q.push_back(s);
      end
      s = '0; s.nsel = 3'b001; s.loadb = 1; exp_q.push_back(s);
      s = '0; s.asel = (opc == 3'b110);
      if (opc == 3'b101 && o == 2'b01) begin
        s.loads = 1; exp_q.push_back(s);
      end else begin
        s.loadc = 1; exp_q.push_back(s);
        s = '0; s.nsel = 3'b010; s.write = 1; exp_q.push_back(s);
      end
    end else if (opc == 3'b011 || opc == 3'b100) begin
      s = '0; s.nsel = 3'b100; s.loada = 1; exp_q.push_back(s);
      s = '0; s.bsel = 1; s.loadc = 1; exp_q.push_back(s);
      s = '0; s.load_addr = 1; exp_q.push_back(s);
      if (opc == 3'b011) begin
        s = '0; s.mem_cmd = 2'b01; exp_q.push_back(s);
        s.nsel = 3'b010; s.vsel = 2'b10; s.write = 1; exp_q.push_back(s);
      end else begin
        s = '0; s.nsel = 3'b010; s.loadb = 1; exp_q.push_back(s);
        s = '0; s.asel = 1; s.loadc = 1; exp_q.push_back(s);
        s = '0; s.mem_cmd = 2'b10; exp_q.push_back(s);
      end
    end else if (opc == 3'b111) begin
      s = '0; s.halted = 1; exp_q.push_back(s);
    end
  endfunction

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  // Runs one instruction starting in IF1 (#1 after the edge). With abort >= 0,
  // reset is asserted in that step and the task returns with reset held low.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int abort);
    opcode = opc;
    op     = o;
    build(opc, o);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("op%b_%b_step%0d", opc, o, i), act, exp_q[i]);
      if (i == abort) begin
        reset_n = 1'b0;
        #1;
        check("async_reset_vec", act, rst_vec());
        check("async_reset_memcmd", {19'd0, mem_cmd}, 21'd0);
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] ro;
    logic [1:0] rp;
    reset_n = 1'b0;
    opcode  = 3'b000;
    op      = 2'b00;
    #12;
    check("reset_state", act, rst_vec());
    @(negedge clk);
    check("reset_held", act, rst_vec());
    release_reset();

    run_instr(3'b110, 2'b10, -1);  // MOV imm
    run_instr(3'b101, 2'b00, -1);  // ADD
    run_instr(3'b101, 2'b01, -1);  // CMP
    run_instr(3'b110, 2'b00, -1);  // MOV reg
    run_instr(3'b011, 2'b00, -1);  // LDR
    run_instr(3'b100, 2'b00, -1);  // STR
    run_instr(3'b010, 2'b00, -1);  // NOP
    run_instr(3'b110, 2'b11, -1);  // NOP (undefined MOV form)

    // Reset during STR_PASS, then resume in IF1.
    run_instr(3'b100, 2'b00, 8);
    @(posedge clk);
    #1;
    check("reset_held_midstr", act, rst_vec());
    release_reset();
    run_instr(3'b101, 2'b10, -1);

    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 6));
      rp = 2'($urandom_range(0, 3));
      run_instr(ro, rp, -1);
    end

    // HALT absorbs regardless of later opcode changes.
    run_instr(3'b111, 2'b00, -1);
    opcode = 3'b110;
    op     = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("halt_hold%0d", k), act, 21'd2 >> 1);
    end
    reset_n = 1'b0;
    #1;
    check("halt_reset", act, rst_vec());
    release_reset();
    run_instr(3'b110, 2'b10, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Moore-style control FSM for the simple RISC core. It sits directly upstream of the datapath, RAM and instruction register. It sequences instruction fetch, PC update, decode and execute, and drives every register-load, mux-select, register-file and memory-command strobe. Instruction fields reach it from the decoder, which reads the instruction register.

## Interface
Parameters: none (ISA encodings fixed below).
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  reset; asynchronous, active-low
- opcode  in  3  instruction[15:13] from decoder
- op  in  2  instruction[12:11] from decoder
- nsel  out  3  register select, one-hot: 100 Rn, 010 Rd, 001 Rm; 000 idle
- vsel  out  2  writeback source: 00 datapath C, 01 sximm8, 10 mdata, 11 unused
- write  out  1  register-file write enable
- loada, loadb, loadc, loads  out  1 each  datapath register loads
- asel  out  1  1 = A operand forced to 0
- bsel  out  1  1 = B operand is sximm5
- load_ir  out  1  instruction register load
- load_pc  out  1  PC load
- reset_pc  out  1  PC next-value = 0 (with load_pc)
- addr_sel  out  1  memory address: 1 = PC, 0 = data address register
- load_addr  out  1  data address register loads datapath C
- mem_cmd  out  2  00 none, 01 read, 10 write, 11 never driven
- halted  out  1  high in HALT state

## Operation
- Pure Moore FSM. Every output is 0 unless listed for the current state.
- RST: reset_pc=1, load_pc=1 → IF1.
- IF1: addr_sel=1, mem_cmd=01 → IF2.
- IF2: addr_sel=1, mem_cmd=01, load_ir=1 → UPDATE_PC.
- UPDATE_PC: load_pc=1 (PC+1) → DECODE.
- DECODE: no outputs. Dispatch on {opcode,op}:
  - 110/10 MOV imm → WR_IMM.
  - 110/00 MOV reg → GET_B.
  - 101/xx ALU → GET_A.
  - 011 LDR → GET_A.
  - 100 STR → GET_A.
  - 111 HALT → HALT.
  - Everything else (000, 001, 010, 110/01, 110/11) is a NOP → IF1.
- WR_IMM: nsel=100, vsel=01, write=1 → IF1.
- GET_A: nsel=100, loada=1. Next state: ADDR if LDR/STR, else GET_B.
- GET_B:
  - MOV/ALU: nsel=001, loadb=1 → COMPUTE.
  - STR: nsel=010, loadb=1 → STR_PASS.
- COMPUTE: bsel=0.
  - asel=1 for MOV reg, else asel=0.
  - If 101/01 (CMP): loads=1 only → IF1.
  - Otherwise: loadc=1 → WR_REG.
- WR_REG: nsel=010, vsel=00, write=1 → IF1.
- ADDR: asel=0, bsel=1, loadc=1 → LOAD_ADDR.
- LOAD_ADDR: load_addr=1. Next: MEM_RD for LDR, GET_B for STR.
- MEM_RD: addr_sel=0, mem_cmd=01 → WR_MEM.
- WR_MEM: addr_sel=0, mem_cmd=01, nsel=010, vsel=10, write=1 → IF1.
- STR_PASS: asel=1, bsel=0, loadc=1 → MEM_WR.
- MEM_WR: addr_sel=0, mem_cmd=10 → IF1.
- HALT: halted=1. Absorbing; only reset_n exits.
- opcode/op are valid from DECODE until the next IF2, because load_ir is asserted only in IF2. Branch decisions in GET_A, GET_B, COMPUTE and LOAD_ADDR use the live inputs.

## Timing
- Reset:
  - reset_n low forces state RST immediately, regardless of clk, even mid-instruction or mid-write.
  - During reset, outputs are the RST values: reset_pc=1, load_pc=1, all others 0, halted=0.
  - First rising edge after reset_n rises enters IF1.
- Common fetch+decode cost: 4 cycles (IF1, IF2, UPDATE_PC, DECODE).
- Instruction cycle counts, from IF1 to the next IF1:
  - MOV imm: 5
  - NOP: 4
  - CMP: 7
  - MOV reg: 7
  - ALU (ADD/AND/MVN): 8
  - LDR: 9
  - STR: 10
- RAM read is synchronous. mdata is valid in the cycle after the first mem_cmd=01 cycle; both IF2 and WR_MEM exploit this.
- mem_cmd=10 lasts exactly one cycle per STR. write lasts exactly one cycle per register-writing instruction.
- addr_sel stays stable across each two-cycle read (IF1/IF2, MEM_RD/WR_MEM).

## Test plan
- Reset mid-STR:
  - Stimulus: assert reset_n=0 in STR_PASS.
  - Response: same cycle, mem_cmd=00, reset_pc=1, load_pc=1.
  - After release: IF1 on the next edge, with addr_sel=1 and mem_cmd=01.
- MOV R3,#5 (opcode 110, op 10):
  - Response: load_ir high only on cycle 2, load_pc on cycle 3.
  - Cycle 5: nsel=100, vsel=01, write=1.
  - Cycle 6: back in IF1.
- ADD (101/00) and CMP (101/01):
  - ADD: GET_A (nsel=100, loada), GET_B (nsel=001, loadb), COMPUTE with loadc, WR_REG with nsel=010. Total 8 cycles.
  - CMP: same through COMPUTE, but loads=1, loadc=0, and no write. Total 7 cycles.
- LDR (opcode 011):
  - Response: ADDR with bsel=1, asel=0, loadc=1, then load_addr=1.
  - Then two cycles of addr_sel=0, mem_cmd=01, with write=1, vsel=10, nsel=010 in the second. Total 9 cycles.
- STR (opcode 100):
  - Response: GET_B reads Rd (nsel=010); STR_PASS has asel=1.
  - Exactly one cycle of mem_cmd=10 with addr_sel=0. write never asserted. Total 10 cycles.
- HALT (111), then opcode changed to 110:
  - Response: halted=1 held indefinitely, with no further load_pc or mem_cmd.
  - Undefined opcode 010 returns to IF1 after DECODE, with no write or loads asserted.
